// File: rtl/alu_multicycle.sv
// alu_multicycle: Sel-decoded ALU; 1-cycle logic/add/sub/slt, WIDTH-step iterative signed MUL/DIV
// Ports: clk, rst_n (async active-low); Start launches an op in IDLE/DONE; Sel op code;
//        A, B operands; Result low product/quotient/result; Hi high product/remainder;
//        Zero, Overflow, DivByZero flags; Busy during ITER/FIX; Done for one cycle in DONE.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [3:0]       Sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivByZero,
  output logic             Busy,
  output logic             Done
);
  localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_MUL = 4'b0011,
                         OP_DIV = 4'b0100, OP_AND = 4'b0101, OP_OR  = 4'b0110,
                         OP_NOR = 4'b0111, OP_SLT = 4'b1000, OP_XOR = 4'b1001;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, mul_nx, div_nx, prod;
  logic [WIDTH-1:0] mb, abs_a, abs_b, sum, dif, s_res, s_hi, fix_res, fix_hi;
  logic [WIDTH:0] mul_sum, trial;
  logic is_div, sgn_lo, sgn_hi, s_ovf, s_dbz, s_ok, accept, multi;
  assign accept  = Start && (state == IDLE || state == DONE);
  assign multi   = Sel == OP_MUL || (Sel == OP_DIV && B != '0);
  assign abs_a   = A[WIDTH-1] ? -A : A;
  assign abs_b   = B[WIDTH-1] ? -B : B;
  assign sum     = A + B;
  assign dif     = A - B;
  // acc holds {hi, lo}: product halves for MUL, {partial remainder, dividend/quotient} for DIV
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};
  assign trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb};
  assign div_nx  = {trial[WIDTH] ? acc[2*WIDTH-2:WIDTH-1] : trial[WIDTH-1:0], acc[WIDTH-2:0], ~trial[WIDTH]};
  assign prod    = sgn_lo ? -acc : acc;
  assign fix_res = is_div ? (sgn_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod[WIDTH-1:0];
  assign fix_hi  = is_div ? (sgn_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
  always_comb begin
    s_res = '0;
    s_hi  = '0;
    s_ovf = 1'b0;
    s_dbz = 1'b0;
    s_ok  = 1'b1;
    case (Sel)
      OP_ADD: begin
        s_res = sum;
        s_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = dif;
        s_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      // only reaches the outputs when B == 0; a real divide goes through ITER
      OP_DIV: begin
        s_res = '1;
        s_hi  = A;
        s_dbz = 1'b1;
        s_ok  = 1'b0;
      end
      OP_AND: s_res = A & B;
      OP_OR:  s_res = A | B;
      OP_NOR: s_res = ~(A | B);
      OP_XOR: s_res = A ^ B;
      OP_SLT: s_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      default: s_ok = 1'b0;
    endcase
  end
  always_comb begin
    state_n = state;
    Busy    = state == ITER || state == FIX;
    Done    = state == DONE;
    case (state)
      IDLE, DONE: state_n = !Start ? IDLE : multi ? ITER : DONE;
      ITER:       state_n = cnt == '0 ? FIX : ITER;
      default:    state_n = DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mb        <= '0;
      is_div    <= 1'b0;
      sgn_lo    <= 1'b0;
      sgn_hi    <= 1'b0;
      Result    <= '0;
      Hi        <= '0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt       <= CW'(WIDTH - 1);
        acc       <= {{WIDTH{1'b0}}, abs_a};
        mb        <= abs_b;
        is_div    <= Sel == OP_DIV;
        sgn_lo    <= A[WIDTH-1] ^ B[WIDTH-1];
        sgn_hi    <= A[WIDTH-1];
        Zero      <= !multi && s_ok && s_res == '0;
        Overflow  <= !multi && s_ovf;
        DivByZero <= !multi && s_dbz;
        if (!multi) begin
          Result <= s_res;
          Hi     <= s_hi;
        end
      end else if (state == ITER) begin
        acc <= is_div ? div_nx : mul_nx;
        cnt <= cnt - 1'b1;
      end else if (state == FIX) begin
        Result <= fix_res;
        Hi     <= fix_hi;
        Zero   <= fix_res == '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle
module tb_alu_multicycle;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0, Start = 1'b0;
  logic [3:0] Sel = '0;
  logic [W-1:0] A = '0, B = '0, Result, Hi;
  logic Zero, Overflow, DivByZero, Busy, Done;
  typedef struct {
    logic [W-1:0] res, hi;
    logic z, o, d;
    int lat;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_bad = 0;
  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Sel(Sel), .A(A), .B(B),
    .Result(Result), .Hi(Hi), .Zero(Zero), .Overflow(Overflow),
    .DivByZero(DivByZero), .Busy(Busy), .Done(Done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask
  function automatic exp_t model(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sbv, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    e.res = '0; e.hi = '0; e.o = 1'b0; e.d = 1'b0; e.lat = 1;
    case (sel)
      4'd1: begin e.res = a + b; e.o = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]); end
      4'd2: begin e.res = a - b; e.o = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]); end
      4'd3: begin p = sa * sbv; e.res = p[W-1:0]; e.hi = p[63:W]; e.lat = W + 2; end
      4'd4: begin
        if (b == '0) begin e.res = '1; e.hi = a; e.d = 1'b1; end
        else begin q = sa / sbv; r = sa % sbv; e.res = q[W-1:0]; e.hi = r[W-1:0]; e.lat = W + 2; end
      end
      4'd5: e.res = a & b;
      4'd6: e.res = a | b;
      4'd7: e.res = ~(a | b);
      4'd8: e.res = (sa < sbv) ? 1 : 0;
      4'd9: e.res = a ^ b;
      default: ;
    endcase
    e.z = sel >= 4'd1 && sel <= 4'd9 && !e.d && e.res == '0;
    return e;
  endfunction
  task automatic run_op(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke = 1'b0);
    exp_t e;
    int lat, busy;
    sb.push_back(model(sel, a, b));
    @(negedge clk);
    Start = 1'b1; Sel = sel; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; A = ~a; B = ~b;
    lat = 1;
    busy = 0;
    while (!Done && lat < 100) begin
      if (Busy) busy++;
      Start = poke && lat == 5;
      @(negedge clk);
      lat++;
    end
    Start = 1'b0;
    e = sb.pop_front();
    chk("done", 64'(Done), 64'd1);
    chk("latency", 64'(lat), 64'(e.lat));
    chk("busy_cycles", 64'(busy), 64'(e.lat - 1));
    chk("result", 64'(Result), 64'(e.res));
    chk("hi", 64'(Hi), 64'(e.hi));
    chk("flags_zod", 64'({Zero, Overflow, DivByZero}), 64'({e.z, e.o, e.d}));
    @(negedge clk);
    chk("done_drop", 64'(Done), 64'd0);
    chk("result_hold", 64'(Result), 64'(e.res));
  endtask
  initial begin
    int dn;
    logic [3:0] rs;
    repeat (2) @(negedge clk);
    chk("rst_vals", {Result, Hi}, 64'd0);
    chk("rst_flags", 64'({Zero, Overflow, DivByZero, Busy, Done}), 64'd0);
    rst_n = 1'b1;
    run_op(4'd1, 32'd5, 32'd7);
    run_op(4'd2, 32'h7FFFFFFF, 32'hFFFFFFFF);
    run_op(4'd2, 32'd9, 32'd9);
    run_op(4'd1, 32'h7FFFFFFF, 32'd1);
    run_op(4'd3, -32'sd3, 32'd7);
    run_op(4'd4, -32'sd7, 32'd2);
    run_op(4'd4, 32'h80000000, 32'hFFFFFFFF);
    run_op(4'd4, 32'd7, -32'sd2);
    run_op(4'd3, 32'h80000000, 32'h80000000);
    run_op(4'd3, 32'd12345, -32'sd678, 1'b1);
    run_op(4'd4, 32'h1234, 32'd0);
    @(negedge clk);
    Start = 1'b1; Sel = 4'd3; A = -32'sd3; B = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_vals", {Result, Hi}, 64'd0);
    chk("abort_flags", 64'({Zero, Overflow, DivByZero, Busy, Done}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      dn += int'(Done);
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    run_op(4'd5, 32'hF0F0, 32'hFF00);
    run_op(4'd6, 32'hF0F0, 32'h0F0F);
    run_op(4'd7, 32'hF0F0, 32'h0F0F);
    run_op(4'd9, 32'hA5A5, 32'hA5A5);
    run_op(4'd8, -32'sd1, 32'd1);
    run_op(4'd8, 32'd1, -32'sd1);
    run_op(4'd0, 32'd3, 32'd4);
    run_op(4'd15, 32'd3, 32'd4);
    repeat (8) begin
      rs = 4'($urandom_range(1, 9));
      run_op(rs, $urandom, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
